mask_unit_read_collector: RTL and testbench
===========================================

Name: mask_unit_read_collector

Overview:
- Sits directly downstream of the mask-unit read crossbar and consumes what it produces.
- Snoops each crossbar output-to-lane handshake and records the request's writeIndex/dataOffset tag in a per-lane in-order FIFO.
- Pairs each lane read response with its oldest tag, byte-aligns the data, and writes it into result slot writeIndex.
- Once every expected slot is filled, presents the assembled group to the mask unit with a valid/ready handshake.

Parameters:
- LANES, 4, number of lanes, crossbar outputs and result slots (writeIndex width = log2(LANES)).
- DATA_W, 32, lane read data width; dataOffset selects a byte, so log2(DATA_W/8) must equal 2.
- TAG_DEPTH, 4, per-lane pending-tag FIFO depth; this bounds the outstanding reads per lane.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- grp_valid  in  1  start a new collection group
- grp_ready  out  1  high only in IDLE
- grp_expect  in  LANES  one bit per slot expected in this group
- req_fire  in  LANES  crossbar output_i valid&ready, as seen at the lane
- req_writeIndex  in  2*LANES  per-lane writeIndex of the fired request
- req_dataOffset  in  2*LANES  per-lane dataOffset of the fired request
- tag_ready  out  LANES  lane i's tag FIFO not full; the integrator ANDs this into crossbar output_i_ready
- rsp_valid  in  LANES  lane read response valid; no backpressure
- rsp_data  in  DATA_W*LANES  lane read data
- out_valid  out  1  assembled group available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W*LANES  slot k at bits [DATA_W*k +: DATA_W]
- out_mask  out  LANES  filled-slot mask (equals grp_expect)
- err_stray  out  1  sticky: response with empty FIFO, or response outside COLLECT
- err_dup  out  1  sticky: slot written twice in one group

Behaviour:
- Reset (reset==0 at a clock edge) has these effects:
  - state=IDLE; all FIFOs empty; filled=0; slot data=0.
  - out_valid=0, out_mask=0, out_data=0; err_*=0; grp_ready=1; tag_ready=all 1s.
  - Reset mid-group discards all pending tags and collected data.
- Tag FIFOs:
  - Lane i enqueues {writeIndex, dataOffset} when req_fire[i]=1.
  - tag_ready[i] = (count_i < TAG_DEPTH), a registered count only. Enqueue while full is a protocol violation (ignored, no error).
  - Lane i dequeues when rsp_valid[i]=1 and the FIFO is non-empty.
  - Simultaneous enqueue and dequeue keeps count unchanged. A response cannot match a same-cycle request; lane latency is at least 1.
- Alignment: slot value = rsp_data_i >> (8*dataOffset), zero-filled at the top.
- State machine:
  - IDLE:
    - grp_ready=1.
    - On grp_valid, latch grp_expect into expect and clear filled, then go to COLLECT.
    - If grp_expect=0, go to DRAIN instead.
  - COLLECT:
    - Each matched response writes slot[writeIndex] and sets filled[writeIndex].
    - Several lanes may write distinct slots in the same cycle.
    - When two lanes target the same slot in one cycle, the lower lane wins and err_dup is set.
    - A write to an already-filled slot, or to a slot not in expect, is dropped and err_dup is set.
    - Leave for DRAIN in the cycle after filled==expect.
  - DRAIN:
    - out_valid=1; out_mask=expect.
    - out_data holds stable until out_valid&out_ready, then go to IDLE.
    - grp_valid is not accepted in the same cycle.
- Stray responses:
  - A response in IDLE/DRAIN still dequeues its tag; the data is dropped and err_stray is set.
  - A response with an empty FIFO is dropped and sets err_stray.
- Latency: last response edge → out_valid high 1 cycle later.
- The err_* flags clear only on reset.

Optional Feature:
- Macro: MASK_READ_COLLECT_PERF_EN.
- When defined:
  - Adds output perf_wait_cycles [15:0], which counts cycles spent in COLLECT and saturates at 0xFFFF.
  - It clears on grp_valid&grp_ready and on reset.
  - Adds output perf_tag_full_cycles [15:0], which counts cycles where any tag_ready bit is 0 and saturates; it clears on reset only.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic group:
  - Stimulus: reset; grp_expect=4'b1111; fire lanes 0..3 with writeIndex 3,2,1,0 and dataOffset 0; responses 2 cycles later with data 0xA0,0xA1,0xA2,0xA3.
  - Required response: out_valid the cycle after the last response; out_data slots = {0xA0,0xA1,0xA2,0xA3} in order 3..0; out_mask=4'hF.
- Alignment:
  - Stimulus: lane 1, writeIndex 0, dataOffset 2, data 0xDEADBEEF.
  - Required response: slot0=0x0000DEAD.
- FIFO full:
  - Stimulus: 4 fires on lane 2 with no responses.
  - Required response: tag_ready[2]=0. After one response, tag_ready[2]=1 the next cycle; responses return in order with the 4 tags, matching enqueue order.
- Duplicate and stray:
  - Stimulus (duplicate): lanes 0 and 1 both target slot 1 in one cycle.
  - Required response: slot1 takes the lane 0 data; err_dup=1.
  - Stimulus (stray): a response on lane 3 with an empty FIFO.
  - Required response: err_stray=1, filled unchanged.
- Backpressure and empty group:
  - Stimulus: hold out_ready=0 for 5 cycles in DRAIN.
  - Required response: out_data stable and grp_ready=0 throughout.
  - Stimulus: grp_expect=0.
  - Required response: out_valid=1 the cycle after acceptance, with out_mask=0.
- Reset mid-group:
  - Stimulus: assert reset with 2 slots filled and 3 tags pending.
  - Required response: after release, out_valid=0, tag_ready=4'hF, and a subsequent response sets err_stray.

Source files
------------

// File: rtl/mask_unit_read_collector.sv
// Collects lane read responses for the mask unit and reorders them into result slots by writeIndex.
// Optional MASK_READ_COLLECT_PERF_EN adds the perf_wait_cycles and perf_tag_full_cycles counters.
module mask_unit_read_collector #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    grp_valid,
  output logic                    grp_ready,
  input  logic [LANES-1:0]        grp_expect,
  input  logic [LANES-1:0]        req_fire,
  input  logic [2*LANES-1:0]      req_writeIndex,
  input  logic [2*LANES-1:0]      req_dataOffset,
  output logic [LANES-1:0]        tag_ready,
  input  logic [LANES-1:0]        rsp_valid,
  input  logic [DATA_W*LANES-1:0] rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic                    err_stray,
  output logic                    err_dup,
  output logic [1:0]              dbgState
`ifdef MASK_READ_COLLECT_PERF_EN
  ,
  output logic [15:0]             perf_wait_cycles,
  output logic [15:0]             perf_tag_full_cycles
`endif
);
  localparam int IW = $clog2(LANES);
  localparam int OW = $clog2(DATA_W / 8);
  localparam int TW = IW + OW;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  // Handshakes: grp and out transfer when valid&ready at a clock edge; rsp has no backpressure.
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, stateNext;

  logic [TW-1:0]     tagMem [LANES][TAG_DEPTH];
  logic [PW-1:0]     wrPtr  [LANES];
  logic [PW-1:0]     rdPtr  [LANES];
  logic [CW-1:0]     count  [LANES];
  logic [DATA_W-1:0] slot   [LANES];
  logic [LANES-1:0]  expectMask, filled;
  logic              errStray, errDup;

  logic [LANES-1:0]  enq, deq, slotWe;
  logic [DATA_W-1:0] slotWd [LANES];
  logic              dupHit, strayHit;

  // Lanes are scanned in ascending order so the lower lane claims a contested slot first.
  always_comb begin
    enq      = '0;
    deq      = '0;
    slotWe   = '0;
    dupHit   = 1'b0;
    strayHit = 1'b0;
    for (int k = 0; k < LANES; k++) slotWd[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [IW-1:0] wi;
      logic [OW-1:0] off;
      {wi, off} = tagMem[i][rdPtr[i]];
      enq[i] = req_fire[i] && (count[i] != CW'(TAG_DEPTH));
      deq[i] = rsp_valid[i] && (count[i] != '0);
      if (rsp_valid[i] && (!deq[i] || state != COLLECT)) begin
        strayHit = 1'b1;
      end else if (deq[i]) begin
        if (!expectMask[wi] || filled[wi] || slotWe[wi]) begin
          dupHit = 1'b1;
        end else begin
          slotWe[wi] = 1'b1;
          slotWd[wi] = rsp_data[DATA_W*i +: DATA_W] >> (8 * off);
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grp_valid) stateNext = (grp_expect == '0) ? DRAIN : COLLECT;
      COLLECT: if (filled == expectMask) stateNext = DRAIN;
      DRAIN:   if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      expectMask <= '0;
      filled     <= '0;
      errStray   <= 1'b0;
      errDup     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
        count[i] <= '0;
        slot[i]  <= '0;
      end
    end else begin
      state <= stateNext;
      if (strayHit) errStray <= 1'b1;
      if (dupHit)   errDup   <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (enq[i]) begin
          tagMem[i][wrPtr[i]] <= {req_writeIndex[2*i +: IW], req_dataOffset[2*i +: OW]};
          wrPtr[i] <= wrPtr[i] + 1'b1;
        end
        if (deq[i]) rdPtr[i] <= rdPtr[i] + 1'b1;
        case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (state == IDLE && grp_valid) begin
        expectMask <= grp_expect;
        filled     <= '0;
        for (int k = 0; k < LANES; k++) slot[k] <= '0;
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (slotWe[k]) begin
            slot[k]   <= slotWd[k];
            filled[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tag_ready[i]                  = (count[i] != CW'(TAG_DEPTH));
      out_data[DATA_W*i +: DATA_W]  = slot[i];
    end
  end

  assign grp_ready = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign out_mask  = (state == DRAIN) ? expectMask : '0;
  assign err_stray = errStray;
  assign err_dup   = errDup;
  assign dbgState  = state;

`ifdef MASK_READ_COLLECT_PERF_EN
  logic [15:0] waitCnt, tagFullCnt;
  always_ff @(posedge clock) begin
    if (!reset) begin
      waitCnt    <= '0;
      tagFullCnt <= '0;
    end else begin
      if (grp_valid && grp_ready) waitCnt <= '0;
      else if (state == COLLECT && waitCnt != 16'hFFFF) waitCnt <= waitCnt + 1'b1;
      if (!(&tag_ready) && tagFullCnt != 16'hFFFF) tagFullCnt <= tagFullCnt + 1'b1;
    end
  end
  assign perf_wait_cycles     = waitCnt;
  assign perf_tag_full_cycles = tagFullCnt;
`endif
endmodule

// File: tb/tb_mask_unit_read_collector.sv
// Bench for mask_unit_read_collector: directed scenarios plus random groups against a queue-based model.
module tb_mask_unit_read_collector;
  logic         clock = 1'b0;
  logic         reset;
  logic         grp_valid;
  logic         grp_ready;
  logic [3:0]   grp_expect;
  logic [3:0]   req_fire;
  logic [7:0]   req_writeIndex;
  logic [7:0]   req_dataOffset;
  logic [3:0]   tag_ready;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_mask;
  logic         err_stray;
  logic         err_dup;
  logic [1:0]   dbgState;
`ifdef MASK_READ_COLLECT_PERF_EN
  logic [15:0]  perf_wait_cycles;
  logic [15:0]  perf_tag_full_cycles;
`endif

  int checks = 0;
  int passes = 0;

  mask_unit_read_collector dut (
    .clock(clock), .reset(reset),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_expect(grp_expect),
    .req_fire(req_fire), .req_writeIndex(req_writeIndex), .req_dataOffset(req_dataOffset),
    .tag_ready(tag_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .err_stray(err_stray), .err_dup(err_dup), .dbgState(dbgState)
`ifdef MASK_READ_COLLECT_PERF_EN
    , .perf_wait_cycles(perf_wait_cycles), .perf_tag_full_cycles(perf_tag_full_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 idle, 1 collecting, 2 presenting.
  int         mPhase;
  logic [3:0] mExpect, mFilled;
  logic [31:0] mSlot[4];
  logic       mErrStray, mErrDup;
  logic [3:0] tagQ[4][$];

  function automatic logic [127:0] laneBits(input logic [3:0] m);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (m[k]) r[32*k +: 32] = 32'hFFFF_FFFF;
    return r;
  endfunction

  function automatic logic [127:0] modelData();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = mSlot[k];
    return r;
  endfunction

  task automatic clearInputs();
    grp_valid = 0; grp_expect = 0; req_fire = 0; req_writeIndex = 0;
    req_dataOffset = 0; rsp_valid = 0; rsp_data = 0;
  endtask

  // Advance one clock: the model consumes the inputs presented this cycle, then pulses are cleared.
  task automatic step();
    int sz[4];
    logic [3:0] filledPre, t;
    logic [1:0] wi, off;
    for (int i = 0; i < 4; i++) sz[i] = tagQ[i].size();
    filledPre = mFilled;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid[i]) begin
        if (sz[i] == 0) mErrStray = 1;
        else begin
          t = tagQ[i].pop_front();
          wi = t[3:2]; off = t[1:0];
          if (mPhase != 1) mErrStray = 1;
          else if (!mExpect[wi] || mFilled[wi]) mErrDup = 1;
          else begin
            mSlot[wi] = rsp_data[32*i +: 32] >> (8 * off);
            mFilled[wi] = 1;
          end
        end
      end
      if (req_fire[i] && sz[i] < 4) tagQ[i].push_back({req_writeIndex[2*i +: 2], req_dataOffset[2*i +: 2]});
    end
    case (mPhase)
      0: if (grp_valid) begin
        mExpect = grp_expect; mFilled = 0;
        for (int k = 0; k < 4; k++) mSlot[k] = 0;
        mPhase = (grp_expect == 0) ? 2 : 1;
      end
      1: if (filledPre == mExpect) mPhase = 2;
      default: if (out_ready) mPhase = 0;
    endcase
    @(posedge clock); #1;
    grp_valid = 0; req_fire = 0; rsp_valid = 0;
  endtask

  task automatic doReset();
    clearInputs();
    out_ready = 0;
    reset = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1;
    mPhase = 0; mExpect = 0; mFilled = 0; mErrStray = 0; mErrDup = 0;
    for (int k = 0; k < 4; k++) begin mSlot[k] = 0; tagQ[k].delete(); end
  endtask

  task automatic startGroup(input logic [3:0] e);
    grp_valid = 1; grp_expect = e; step();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (grp_ready !== 1'b1) $display("FAIL reset_grp_ready: got %b want 1", grp_ready); else passes++;
    checks++; if (tag_ready !== 4'hF) $display("FAIL reset_tag_ready: got %h want f", tag_ready); else passes++;
    checks++; if (out_data !== 128'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else passes++;
    checks++; if (out_mask !== 4'h0) $display("FAIL reset_out_mask: got %h want 0", out_mask); else passes++;
    checks++; if ({err_stray, err_dup} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_stray, err_dup}); else passes++;
  endtask

  task automatic test_basic();
    startGroup(4'hF);
    req_fire = 4'hF; req_writeIndex = {2'd0, 2'd1, 2'd2, 2'd3}; req_dataOffset = 0; step();
    step();
    rsp_valid = 4'hF; rsp_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; step();
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== 128'h000000A0_000000A1_000000A2_000000A3)
      $display("FAIL basic_data: got %h want %h", out_data, 128'h000000A0_000000A1_000000A2_000000A3); else passes++;
    checks++; if (out_mask !== 4'hF) $display("FAIL basic_mask: got %h want f", out_mask); else passes++;
    out_ready = 1; step(); out_ready = 0;
    checks++; if (grp_ready !== 1'b1) $display("FAIL basic_idle: got %b want 1", grp_ready); else passes++;
  endtask

  task automatic test_align();
    for (int n = 0; n < 4; n++) begin
      int lane, sl, off;
      logic [31:0] d, want;
      lane = (n == 0) ? 1 : $urandom_range(3, 0);
      sl   = (n == 0) ? 0 : $urandom_range(3, 0);
      off  = (n == 0) ? 2 : $urandom_range(3, 0);
      d    = (n == 0) ? 32'hDEADBEEF : $urandom;
      want = d >> (8 * off);
      startGroup(4'(1 << sl));
      req_fire[lane] = 1; req_writeIndex[2*lane +: 2] = 2'(sl); req_dataOffset[2*lane +: 2] = 2'(off); step();
      rsp_valid[lane] = 1; rsp_data = 0; rsp_data[32*lane +: 32] = d; step();
      step();
      checks++; if (out_data[32*sl +: 32] !== want || out_valid !== 1'b1)
        $display("FAIL align_%0d: got %h valid %b want %h", n, out_data[32*sl +: 32], out_valid, want); else passes++;
      out_ready = 1; step(); out_ready = 0;
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d0;
    logic [1:0]  off0;
    startGroup(4'hF);
    for (int k = 0; k < 4; k++) begin
      req_fire = 4'b0100; req_writeIndex = 0; req_dataOffset = 0;
      req_writeIndex[5:4] = 2'(k); req_dataOffset[5:4] = 2'($urandom_range(3, 0));
      if (k == 0) off0 = req_dataOffset[5:4];
      step();
    end
    checks++; if (tag_ready[2] !== 1'b0) $display("FAIL fifo_full: got %b want 0", tag_ready[2]); else passes++;
    d0 = $urandom;
    rsp_valid = 4'b0100; rsp_data = 0; rsp_data[95:64] = d0; step();
    checks++; if (tag_ready[2] !== 1'b1) $display("FAIL fifo_not_full: got %b want 1", tag_ready[2]); else passes++;
    for (int k = 1; k < 4; k++) begin
      rsp_valid = 4'b0100; rsp_data = 0; rsp_data[95:64] = $urandom; step();
    end
    step();
    checks++; if (out_valid !== 1'b1) $display("FAIL fifo_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_data[31:0] !== (d0 >> (8 * off0)))
      $display("FAIL fifo_first_tag: got %h want %h", out_data[31:0], d0 >> (8 * off0)); else passes++;
    checks++; if (out_data !== modelData()) $display("FAIL fifo_order: got %h want %h", out_data, modelData()); else passes++;
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_dup_stray();
    logic [31:0] dA, dB, dC;
    dA = $urandom; dB = $urandom; dC = $urandom;
    startGroup(4'b0011);
    req_fire = 4'b0011; req_writeIndex = 8'b0000_0101; req_dataOffset = 0; step();
    rsp_valid = 4'b0011; rsp_data = {64'h0, dB, dA}; step();
    checks++; if (err_dup !== 1'b1) $display("FAIL dup_flag: got %b want 1", err_dup); else passes++;
    checks++; if (err_stray !== 1'b0) $display("FAIL dup_no_stray: got %b want 0", err_stray); else passes++;
    rsp_valid = 4'b1000; rsp_data = {$urandom, 96'h0}; step();
    checks++; if (err_stray !== 1'b1) $display("FAIL stray_flag: got %b want 1", err_stray); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL stray_filled: got %b want 0", out_valid); else passes++;
    req_fire = 4'b0100; req_writeIndex = 0; req_dataOffset = 0; step();
    rsp_valid = 4'b0100; rsp_data = {32'h0, dC, 64'h0}; step();
    step();
    checks++; if (out_data[63:0] !== {dA, dC} || out_valid !== 1'b1)
      $display("FAIL dup_winner: got %h want %h", out_data[63:0], {dA, dC}); else passes++;
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_backpressure();
    int perm[4];
    logic [127:0] snap;
    for (int i = 0; i < 4; i++) perm[i] = i;
    for (int i = 3; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    startGroup(4'hF);
    req_fire = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_writeIndex[2*i +: 2] = 2'(perm[i]); req_dataOffset[2*i +: 2] = 2'($urandom_range(3, 0));
    end
    step();
    for (int w = $urandom_range(2, 0); w > 0; w--) step();
    rsp_valid = 4'hF; rsp_data = {$urandom, $urandom, $urandom, $urandom}; step();
    step();
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== modelData()) $display("FAIL bp_data: got %h want %h", out_data, modelData()); else passes++;
    snap = modelData();
    for (int c = 0; c < 5; c++) begin
      grp_valid = 1; grp_expect = 4'hF; step();
      checks++; if (out_data !== snap || grp_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold_%0d: got %h ready %b valid %b want %h ready 0 valid 1", c, out_data, grp_ready, out_valid, snap);
      else passes++;
    end
    out_ready = 1; step(); out_ready = 0;
    startGroup(4'h0);
    checks++; if (out_valid !== 1'b1 || out_mask !== 4'h0)
      $display("FAIL empty_group: got valid %b mask %h want valid 1 mask 0", out_valid, out_mask); else passes++;
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_random();
    for (int g = 0; g < 8; g++) begin
      logic [3:0] e;
      int budget;
      e = 4'($urandom_range(15, 0));
      startGroup(e);
      for (int k = 0; k < 4; k++) begin
        if (e[k]) begin
          int lane;
          lane = $urandom_range(3, 0);
          req_fire[lane] = 1; req_writeIndex[2*lane +: 2] = 2'(k);
          req_dataOffset[2*lane +: 2] = 2'($urandom_range(3, 0));
          step();
        end
      end
      budget = 60;
      while (mPhase != 2 && budget > 0) begin
        for (int i = 0; i < 4; i++) rsp_valid[i] = (tagQ[i].size() != 0) && ($urandom_range(1, 0) == 1);
        rsp_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        budget--;
      end
      checks++; if (mPhase != 2 || out_valid !== 1'b1)
        $display("FAIL rand_%0d_valid: got %b want 1 (model phase %0d)", g, out_valid, mPhase); else passes++;
      checks++; if ((out_data & laneBits(mExpect)) !== (modelData() & laneBits(mExpect)) || out_mask !== mExpect)
        $display("FAIL rand_%0d_data: got %h mask %h want %h mask %h", g, out_data & laneBits(mExpect), out_mask,
                 modelData() & laneBits(mExpect), mExpect); else passes++;
      checks++; if ({err_stray, err_dup} !== {mErrStray, mErrDup})
        $display("FAIL rand_%0d_err: got %b want %b", g, {err_stray, err_dup}, {mErrStray, mErrDup}); else passes++;
      for (int w = $urandom_range(2, 0); w > 0; w--) step();
      out_ready = 1; step(); out_ready = 0;
    end
  endtask

  task automatic test_reset_mid();
    startGroup(4'hF);
    req_fire = 4'b0011; req_writeIndex = 8'b0000_0100; req_dataOffset = 0; step();
    rsp_valid = 4'b0011; rsp_data = {$urandom, $urandom, $urandom, $urandom}; step();
    for (int k = 0; k < 3; k++) begin
      req_fire = 4'b0100; req_writeIndex = 0; req_writeIndex[5:4] = 2'(2 + (k % 2)); step();
    end
    doReset();
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else passes++;
    checks++; if (tag_ready !== 4'hF) $display("FAIL rmid_tag_ready: got %h want f", tag_ready); else passes++;
    checks++; if (err_stray !== 1'b0) $display("FAIL rmid_stray_clear: got %b want 0", err_stray); else passes++;
    rsp_valid = 4'b0100; rsp_data = {$urandom, $urandom, $urandom, $urandom}; step();
    checks++; if (err_stray !== 1'b1) $display("FAIL rmid_stray: got %b want 1", err_stray); else passes++;
  endtask

  initial begin
    reset = 0;
    out_ready = 0;
    clearInputs();
    test_reset();
    test_basic();
    test_align();
    test_fifo_full();
    test_dup_stray();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
